// File: rtl/bbox_sweep_ctrl_if.sv
// Host-side table/sweep signals and the intersect-unit link of bbox_sweep_ctrl.
// Coordinates are signed 24-bit; vec3 = {x,y,z}, vec2 = {x,y}, bbox = {min,max}, first field in the MSBs.
interface bbox_sweep_ctrl_if #(
  parameter int MAX_BOXES = 16
);
  localparam int IDX_W = $clog2(MAX_BOXES);
  localparam int C_W   = 24;

  logic                 box_wr_en;
  logic [IDX_W-1:0]     box_wr_addr;
  logic [6*C_W-1:0]     box_wr_data;
  logic                 start;
  logic [IDX_W:0]       num_boxes;
  logic [3*C_W-1:0]     ray_orig;
  logic [3*C_W-1:0]     inv_ray_dir;
  logic                 busy;
  logic                 done;
  logic                 any_hit;
  logic [IDX_W-1:0]     closest_idx;
  logic [2*C_W-1:0]     closest_range;
  logic [3*C_W-1:0]     isect_ray_orig;
  logic [3*C_W-1:0]     isect_inv_ray_dir;
  logic [6*C_W-1:0]     isect_box;
  logic [2*C_W-1:0]     isect_prev_range;
  logic                 isect_hit;
  logic [2*C_W-1:0]     isect_range;

  modport master (
    output box_wr_en, box_wr_addr, box_wr_data, start, num_boxes, ray_orig, inv_ray_dir,
    output isect_hit, isect_range,
    input  busy, done, any_hit, closest_idx, closest_range,
    input  isect_ray_orig, isect_inv_ray_dir, isect_box, isect_prev_range
  );

  modport slave (
    input  box_wr_en, box_wr_addr, box_wr_data, start, num_boxes, ray_orig, inv_ray_dir,
    input  isect_hit, isect_range,
    output busy, done, any_hit, closest_idx, closest_range,
    output isect_ray_orig, isect_inv_ray_dir, isect_box, isect_prev_range
  );
endinterface

// File: rtl/bbox_sweep_ctrl.sv
// Sweeps a box table through one shared ray/box intersect pipeline and keeps the nearest hit.
// Tags travel alongside the pipeline so results are matched to the box index that produced them.
module bbox_sweep_ctrl #(
  parameter int MAX_BOXES = 16,
  parameter int ISECT_LAT = 2
) (
  input  logic             sysclk,
  input  logic             rst_n,
  bbox_sweep_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(MAX_BOXES);
  localparam int C_W   = 24;
  localparam int V2_W  = 2 * C_W;
  localparam int V3_W  = 3 * C_W;
  localparam int BOX_W = 6 * C_W;
  localparam logic [C_W-1:0]   INFINITY_24          = 24'h7F_FFFF;
  localparam logic [C_W-1:0]   NEGATIVE_INFINITY_24 = 24'h80_0000;
  localparam logic [IDX_W:0]   CNT_ZERO = {(IDX_W+1){1'b0}};
  localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                          state_r, state_s;
  logic                            busy_r, done_r;
  logic [BOX_W-1:0]                table_r [MAX_BOXES];
  logic [IDX_W-1:0]                issue_idx_r;
  logic [IDX_W-1:0]                issue_next_s;
  logic [IDX_W:0]                  num_boxes_r;
  logic [BOX_W-1:0]                isect_box_r;
  logic [V3_W-1:0]                 ray_orig_r, inv_dir_r;
  logic [ISECT_LAT-1:0]            tag_valid_r;
  logic [ISECT_LAT-1:0][IDX_W-1:0] tag_idx_r;
  logic                            pending_s, last_issue_s, accept_s, hit_valid_s, closer_s;
  logic                            any_hit_r;
  logic signed [C_W-1:0]           best_t_r;
  logic [IDX_W-1:0]                closest_idx_r;
  logic [V2_W-1:0]                 closest_range_r;

  assign accept_s     = (state_r == ST_IDLE) && bus.start;
  assign issue_next_s = issue_idx_r + IDX_ONE;
  assign last_issue_s = ({1'b0, issue_idx_r} == (num_boxes_r - CNT_ONE));
  assign hit_valid_s  = tag_valid_r[ISECT_LAT-1] && bus.isect_hit;
  assign closer_s     = $signed(bus.isect_range[V2_W-1 -: C_W]) < best_t_r;

  // Any valid tag short of the output slot means results are still in flight.
  always_comb begin
    pending_s = 1'b0;
    for (int i = 0; i < ISECT_LAT - 1; i++) begin
      pending_s = pending_s | tag_valid_r[i];
    end
  end

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.num_boxes == CNT_ZERO) state_s = ST_DONE;
          else                           state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (last_issue_s) state_s = ST_DRAIN;
        else              state_s = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (!pending_s) state_s = ST_DONE;
        else            state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register with busy/done decoded from the next state so they leave as flops.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_ISSUE) || (state_s == ST_DRAIN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Box table; only writable while idle.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_BOXES; i++) table_r[i] <= {BOX_W{1'b0}};
    end else if ((state_r == ST_IDLE) && bus.box_wr_en) begin
      table_r[bus.box_wr_addr] <= bus.box_wr_data;
    end
  end

  // Issue path: the table read is registered, so a same-edge write to entry 0 is not seen by box 0.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      issue_idx_r <= IDX_ZERO;
      num_boxes_r <= CNT_ZERO;
      isect_box_r <= {BOX_W{1'b0}};
      ray_orig_r  <= {V3_W{1'b0}};
      inv_dir_r   <= {V3_W{1'b0}};
    end else if (accept_s) begin
      issue_idx_r <= IDX_ZERO;
      num_boxes_r <= bus.num_boxes;
      isect_box_r <= table_r[IDX_ZERO];
      ray_orig_r  <= bus.ray_orig;
      inv_dir_r   <= bus.inv_ray_dir;
    end else if (state_r == ST_ISSUE) begin
      issue_idx_r <= issue_next_s;
      isect_box_r <= table_r[issue_next_s];
    end
  end

  // Tag shift register mirroring the intersect latency; cleared on reset to drop in-flight work.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_r <= {ISECT_LAT{1'b0}};
      tag_idx_r   <= {(ISECT_LAT*IDX_W){1'b0}};
    end else begin
      tag_valid_r[0] <= (state_r == ST_ISSUE);
      tag_idx_r[0]   <= issue_idx_r;
      for (int i = 1; i < ISECT_LAT; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
        tag_idx_r[i]   <= tag_idx_r[i-1];
      end
    end
  end

  // Nearest-hit reduction; strict less-than keeps the lower index on ties.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      any_hit_r       <= 1'b0;
      best_t_r        <= INFINITY_24;
      closest_idx_r   <= IDX_ZERO;
      closest_range_r <= {V2_W{1'b0}};
    end else if (accept_s) begin
      any_hit_r     <= 1'b0;
      best_t_r      <= INFINITY_24;
      closest_idx_r <= IDX_ZERO;
    end else if (hit_valid_s) begin
      any_hit_r <= 1'b1;
      if (closer_s) begin
        best_t_r        <= $signed(bus.isect_range[V2_W-1 -: C_W]);
        closest_range_r <= bus.isect_range;
        closest_idx_r   <= tag_idx_r[ISECT_LAT-1];
      end
    end
  end

  assign bus.busy              = busy_r;
  assign bus.done              = done_r;
  assign bus.any_hit           = any_hit_r;
  assign bus.closest_idx       = closest_idx_r;
  assign bus.closest_range     = closest_range_r;
  assign bus.isect_ray_orig    = ray_orig_r;
  assign bus.isect_inv_ray_dir = inv_dir_r;
  assign bus.isect_box         = isect_box_r;
  assign bus.isect_prev_range  = {INFINITY_24, NEGATIVE_INFINITY_24};
endmodule

// File: tb/tb_bbox_sweep_ctrl.sv
// Bench for bbox_sweep_ctrl: a latency-matched slab-test intersect unit plus an array-based nearest-hit model.
module tb_bbox_sweep_ctrl;
  localparam int MAX_BOXES = 16;
  localparam int ISECT_LAT = 2;
  localparam int IDX_W     = $clog2(MAX_BOXES);

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 sysclk = ~sysclk;

  bbox_sweep_ctrl_if #(.MAX_BOXES(MAX_BOXES)) bus ();
  bbox_sweep_ctrl #(.MAX_BOXES(MAX_BOXES), .ISECT_LAT(ISECT_LAT)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [143:0] mtab [MAX_BOXES];
  logic [48:0]  isect_pipe [ISECT_LAT];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] v3(input int x, input int y, input int z);
    return {24'(x), 24'(y), 24'(z)};
  endfunction

  function automatic logic [143:0] mk_box(input int x, input int y, input int z, input int s);
    return {v3(x, y, z), v3(x + s, y + s, z + s)};
  endfunction

  // Slab test with integer inverse direction: returns {hit, t_entry, t_exit}.
  function automatic logic [48:0] slab(input logic [143:0] box, input logic [71:0] o, input logic [71:0] d);
    int tn, tf, t1, t2, mn, mx, oo, dd;
    tn = -1000000;
    tf = 1000000;
    for (int a = 0; a < 3; a++) begin
      mn = int'($signed(box[143-24*a -: 24]));
      mx = int'($signed(box[71-24*a -: 24]));
      oo = int'($signed(o[71-24*a -: 24]));
      dd = int'($signed(d[71-24*a -: 24]));
      t1 = (mn - oo) * dd;
      t2 = (mx - oo) * dd;
      if (t1 > t2) begin
        tn = (t2 > tn) ? t2 : tn;
        tf = (t1 < tf) ? t1 : tf;
      end else begin
        tn = (t1 > tn) ? t1 : tn;
        tf = (t2 < tf) ? t2 : tf;
      end
    end
    return {(tf >= tn) && (tf >= 0), 24'(tn), 24'(tf)};
  endfunction

  // Intersect unit stand-in: ISECT_LAT register stages, deliberately not reset.
  always @(posedge sysclk) begin
    isect_pipe[0] <= slab(bus.isect_box, bus.isect_ray_orig, bus.isect_inv_ray_dir);
    for (int i = 1; i < ISECT_LAT; i++) isect_pipe[i] <= isect_pipe[i-1];
  end
  assign bus.isect_hit   = isect_pipe[ISECT_LAT-1][48];
  assign bus.isect_range = isect_pipe[ISECT_LAT-1][47:0];

  task automatic write_box(input int addr, input logic [143:0] data);
    bus.box_wr_en   = 1'b1;
    bus.box_wr_addr = IDX_W'(addr);
    bus.box_wr_data = data;
    @(negedge sysclk);
    bus.box_wr_en = 1'b0;
    mtab[addr] = data;
  endtask

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_busy"}, 64'(bus.busy), 64'd0);
    check_eq({pfx, "_done"}, 64'(bus.done), 64'd0);
    check_eq({pfx, "_any_hit"}, 64'(bus.any_hit), 64'd0);
    check_eq({pfx, "_idx"}, 64'(bus.closest_idx), 64'd0);
    check_eq({pfx, "_range"}, 64'(bus.closest_range), 64'd0);
    check_eq({pfx, "_box_lo"}, bus.isect_box[63:0], 64'd0);
    check_eq({pfx, "_orig"}, 64'(bus.isect_ray_orig[63:0]), 64'd0);
    check_eq({pfx, "_dir"}, 64'(bus.isect_inv_ray_dir[63:0]), 64'd0);
  endtask

  // Runs one sweep from a negedge; returns at a negedge with the DUT idle.
  task automatic run_sweep(input string tag, input int n, input logic [71:0] o, input logic [71:0] d,
                           input bit junk, input bit sim_wr, input int wr_addr, input logic [143:0] wr_data,
                           output int got_idx);
    logic [143:0] snap [MAX_BOXES];
    logic [48:0]  r;
    logic [47:0]  best_r;
    logic         exp_hit, cap_hit;
    logic [47:0]  cap_range;
    int best_i, done_cyc, done_cnt, busy_cnt, cap_idx, exp_done;
    for (int k = 0; k < MAX_BOXES; k++) snap[k] = mtab[k];
    if (sim_wr) begin
      mtab[wr_addr] = wr_data;
      if (wr_addr != 0) snap[wr_addr] = wr_data;
    end
    exp_hit = 1'b0;
    best_i  = 0;
    best_r  = 48'd0;
    for (int k = 0; k < n; k++) begin
      r = slab(snap[k], o, d);
      if (r[48] && (!exp_hit || ($signed(r[47:24]) < $signed(best_r[47:24])))) begin
        best_i = k;
        best_r = r[47:0];
      end
      if (r[48]) exp_hit = 1'b1;
    end
    exp_done = (n == 0) ? 1 : n + ISECT_LAT + 1;

    bus.start       = 1'b1;
    bus.num_boxes   = (IDX_W+1)'(n);
    bus.ray_orig    = o;
    bus.inv_ray_dir = d;
    if (sim_wr) begin
      bus.box_wr_en   = 1'b1;
      bus.box_wr_addr = IDX_W'(wr_addr);
      bus.box_wr_data = wr_data;
    end
    @(negedge sysclk);
    bus.start     = 1'b0;
    bus.box_wr_en = 1'b0;
    done_cyc = -1; done_cnt = 0; busy_cnt = 0;
    cap_hit = 1'b0; cap_idx = 0; cap_range = 48'd0;
    for (int cyc = 1; cyc <= n + ISECT_LAT + 4; cyc++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc  = cyc;
          cap_hit   = bus.any_hit;
          cap_idx   = int'(bus.closest_idx);
          cap_range = bus.closest_range;
        end
      end
      if (junk && cyc == 1) begin
        bus.start       = 1'b1;
        bus.num_boxes   = (IDX_W+1)'(MAX_BOXES);
        bus.box_wr_en   = 1'b1;
        bus.box_wr_addr = IDX_W'(0);
        bus.box_wr_data = mk_box(0, 0, 0, 1);
      end else if (junk && cyc == 2) begin
        bus.start     = 1'b0;
        bus.box_wr_en = 1'b0;
      end
      @(negedge sysclk);
    end
    check_eq({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
    check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_busy_cnt"}, 64'(busy_cnt), 64'((n == 0) ? 0 : n + ISECT_LAT));
    check_eq({tag, "_any_hit"}, 64'(cap_hit), 64'(exp_hit));
    if (exp_hit) begin
      check_eq({tag, "_idx"}, 64'(cap_idx), 64'(best_i));
      check_eq({tag, "_range"}, 64'(cap_range), 64'(best_r));
    end
    check_eq({tag, "_hold_hit"}, 64'(bus.any_hit), 64'(exp_hit));
    got_idx = cap_idx;
  endtask

  initial begin
    int got, n, nw;
    bus.box_wr_en = 1'b0; bus.box_wr_addr = '0; bus.box_wr_data = '0;
    bus.start = 1'b0; bus.num_boxes = '0; bus.ray_orig = '0; bus.inv_ray_dir = '0;
    for (int k = 0; k < MAX_BOXES; k++) mtab[k] = 144'd0;
    repeat (3) @(negedge sysclk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge sysclk);
    check_eq("prev_range", 64'(bus.isect_prev_range), 64'h7FFFFF800000);

    // Three boxes, two hits
    write_box(0, mk_box(20, 20, 20, 10));
    write_box(1, mk_box(0, 0, 0, 10));
    write_box(2, mk_box(-30, -30, -30, 10));
    run_sweep("t1", 3, v3(0, 0, 0), v3(1, 1, 1), 1'b0, 1'b0, 0, 144'd0, got);
    check_eq("t1_idx_fixed", 64'(got), 64'd1);
    check_eq("t1_range_x", 64'(bus.closest_range[47:24]), 64'd0);

    run_sweep("t2", 0, v3(0, 0, 0), v3(1, 1, 1), 1'b0, 1'b0, 0, 144'd0, got);

    // Tie between identical boxes 2 and 5, with ignored start/write while busy
    for (int k = 0; k < 6; k++) write_box(k, mk_box(-40, -40, -40, 10));
    write_box(2, mk_box(10, 10, 10, 10));
    write_box(5, mk_box(10, 10, 10, 10));
    run_sweep("t3", 6, v3(0, 0, 0), v3(1, 1, 1), 1'b1, 1'b0, 0, 144'd0, got);
    check_eq("t3_idx_fixed", 64'(got), 64'd2);
    run_sweep("t4", 6, v3(0, 0, 0), v3(1, 1, 1), 1'b0, 1'b0, 0, 144'd0, got);
    check_eq("t4_idx_fixed", 64'(got), 64'd2);

    // Full table, only the last entry hit
    for (int k = 0; k < MAX_BOXES; k++) write_box(k, mk_box(-60, -60, -60, 20));
    write_box(MAX_BOXES - 1, mk_box(30, 30, 30, 5));
    run_sweep("t6", MAX_BOXES, v3(0, 0, 0), v3(1, 1, 1), 1'b0, 1'b0, 0, 144'd0, got);
    check_eq("t6_idx_fixed", 64'(got), 64'(MAX_BOXES - 1));

    // Reset during DRAIN of a 16-box sweep full of hits
    for (int k = 0; k < MAX_BOXES; k++) write_box(k, mk_box(0, 0, 0, 10 + k));
    bus.start = 1'b1; bus.num_boxes = (IDX_W+1)'(MAX_BOXES);
    bus.ray_orig = v3(5, 5, 5); bus.inv_ray_dir = v3(1, 1, 1);
    @(negedge sysclk);
    bus.start = 1'b0;
    repeat (MAX_BOXES) @(negedge sysclk);
    check_eq("t5_busy_drain", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset("t5_rst");
    @(negedge sysclk);
    rst_n = 1'b1;
    for (int k = 0; k < MAX_BOXES; k++) mtab[k] = 144'd0;
    run_sweep("t5", 1, v3(5, 5, 5), v3(1, 1, 1), 1'b0, 1'b0, 0, 144'd0, got);

    // Randomized sweeps, including simultaneous start+write and ignored inputs
    for (int it = 0; it < 30; it++) begin
      nw = int'($urandom_range(6));
      for (int w = 0; w < nw; w++)
        write_box(int'($urandom_range(MAX_BOXES - 1)),
                  mk_box(int'($urandom_range(200)) - 100, int'($urandom_range(200)) - 100,
                         int'($urandom_range(200)) - 100, int'($urandom_range(1, 60))));
      n = int'($urandom_range(MAX_BOXES));
      run_sweep($sformatf("rnd%0d", it), n,
                v3(int'($urandom_range(40)) - 20, int'($urandom_range(40)) - 20, int'($urandom_range(40)) - 20),
                v3(($urandom_range(1) != 0) ? int'($urandom_range(1, 3)) : -int'($urandom_range(1, 3)),
                   ($urandom_range(1) != 0) ? int'($urandom_range(1, 3)) : -int'($urandom_range(1, 3)),
                   ($urandom_range(1) != 0) ? int'($urandom_range(1, 3)) : -int'($urandom_range(1, 3))),
                (n > 0) && ($urandom_range(1) != 0), $urandom_range(3) == 0,
                ($urandom_range(1) != 0) ? 0 : int'($urandom_range(MAX_BOXES - 1)),
                mk_box(int'($urandom_range(100)) - 50, int'($urandom_range(100)) - 50,
                       int'($urandom_range(100)) - 50, int'($urandom_range(1, 60))), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
